// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
package serial_pkg;

    // Frame phases, in the order they appear on the line.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Line levels for the idle/stop condition and for the start bit.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clock cycles while enabled and flags
// the last cycle of each serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The strobe marks the final cycle of the current bit; the counter restarts
    // from zero there, so it never runs past the bit boundary.
    assign bit_end_o = en_i && (cnt_q == LAST_CNT);

    // Next count: held at zero while idle, wraps at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even
// parity bit, stop bit. The line output is registered and idles high.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              sdo,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic              parity_q;
    logic              parity_d;
    logic              sdo_q;
    logic              sdo_d;
    logic              bit_end;
    logic              timer_en;
    logic              accept;

    assign timer_en = (state_q != IDLE);
    assign accept   = tx_valid && (state_q == IDLE);

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == STOP) && bit_end;
    assign sdo      = sdo_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (timer_en),
        .bit_end_o(bit_end)
    );

    // Frame sequencing: latch word and parity on acceptance, step through the
    // phases on each bit_end, shifting the payload down one bit per data bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    parity_d  = ^tx_data;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next phase so that the
    // registered output lines up with the phase it belongs to.
    always_comb begin
        sdo_d = IDLE_LEVEL;
        case (state_d)
            START:   sdo_d = START_LEVEL;
            DATA:    sdo_d = shift_d[0];
            PARITY:  sdo_d = parity_d;
            default: sdo_d = IDLE_LEVEL;
        endcase
    end

    // State, payload, counters and line output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            sdo_q     <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            sdo_q     <= sdo_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: default build plus a no-parity,
// one-cycle-per-bit build, compared cycle by cycle against a frame model.
module tb_serial_tx;

    localparam int FRAME  = (2 + 8 + 1) * 4;
    localparam int FRAME2 = (2 + 8 + 0) * 1;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       sdo;
    logic       busy;
    logic       done;

    logic       tx_valid2;
    logic [7:0] tx_data2;
    logic       tx_ready2;
    logic       sdo2;
    logic       busy2;
    logic       done2;

    int checkCount;
    int failCount;

    serial_tx #(
        .DATA_W      (8),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .sdo     (sdo),
        .busy    (busy),
        .done    (done)
    );

    serial_tx #(
        .DATA_W      (8),
        .CLKS_PER_BIT(1),
        .PARITY_EN   (0)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid2),
        .tx_data (tx_data2),
        .tx_ready(tx_ready2),
        .sdo     (sdo2),
        .busy    (busy2),
        .done    (done2)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference line level for cycle c (1-based, counted from acceptance)
    // of a frame carrying w: start, 8 data bits LSB first, parity, stop.
    function automatic logic expBit(input logic [7:0] w, input int c, input int cpb, input int parEn);
        int b;
        b = (c - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (parEn != 0 && b == 9) return ^w;
        return 1'b1;
    endfunction

    // One idle cycle on the default instance.
    task automatic idleCycle();
        @(negedge clk);
        checkOutput("idle_sdo", 32'(sdo), 32'd1);
        checkOutput("idle_ready", 32'(tx_ready), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
    endtask

    // Called at a negedge with tx_valid/tx_data already driven; accepts the
    // word at the next rising edge and checks cycles 1..lastCycle of the frame.
    task automatic applyStimulus(input logic [7:0] word, input bit hold, input logic [7:0] nextWord,
                                 input int corruptCycle, input int lastCycle);
        checkOutput("accept_ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= lastCycle; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) tx_valid = 1'b0;
            if (c == corruptCycle) begin
                tx_data = ~word;
                if (!hold) tx_valid = 1'b1;
            end
            if (c == corruptCycle + 1 && !hold) tx_valid = 1'b0;
            checkOutput("frame_sdo", 32'(sdo), 32'(expBit(word, c, 4, 1)));
            checkOutput("frame_busy", 32'(busy), 32'd1);
            checkOutput("frame_ready", 32'(tx_ready), 32'd0);
            checkOutput("frame_done", 32'(done), (c == FRAME) ? 32'd1 : 32'd0);
            if (c == FRAME && hold) tx_data = nextWord;
        end
    endtask

    // One frame on the no-parity, single-cycle-bit instance.
    task automatic applyStimulus2(input logic [7:0] word);
        @(negedge clk);
        tx_valid2 = 1'b1;
        tx_data2  = word;
        checkOutput("p2_ready", 32'(tx_ready2), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= FRAME2; c++) begin
            @(negedge clk);
            if (c == 1) tx_valid2 = 1'b0;
            checkOutput("p2_sdo", 32'(sdo2), 32'(expBit(word, c, 1, 0)));
            checkOutput("p2_busy", 32'(busy2), 32'd1);
            checkOutput("p2_done", 32'(done2), (c == FRAME2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        checkOutput("p2_idle_sdo", 32'(sdo2), 32'd1);
        checkOutput("p2_idle_busy", 32'(busy2), 32'd0);
    endtask

    initial begin
        logic [7:0] word;
        logic [7:0] nextWord;
        bit         hold;
        bit         armed;
        int         corrupt;

        checkCount = 0;
        failCount  = 0;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_valid2 = 1'b0;
        tx_data2  = 8'h00;

        // Reset state
        #2;
        checkOutput("rst_sdo", 32'(sdo), 32'd1);
        checkOutput("rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame 8'hA5
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        applyStimulus(8'hA5, 1'b0, 8'h00, 0, FRAME);
        idleCycle();

        // Back-to-back 8'h3C then 8'hFF with tx_valid held
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        applyStimulus(8'h3C, 1'b1, 8'hFF, 0, FRAME);
        idleCycle();
        applyStimulus(8'hFF, 1'b0, 8'h00, 0, FRAME);
        idleCycle();

        // Inputs changed mid-frame must not disturb the latched word
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        applyStimulus(8'hA5, 1'b0, 8'h00, 10, FRAME);
        idleCycle();

        // Reset during data bit 3 of 8'h01
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        applyStimulus(8'h01, 1'b0, 8'h00, 0, 18);
        #1 rst = 1'b1;
        #1;
        checkOutput("mrst_sdo", 32'(sdo), 32'd1);
        checkOutput("mrst_ready", 32'(tx_ready), 32'd1);
        checkOutput("mrst_busy", 32'(busy), 32'd0);
        checkOutput("mrst_done", 32'(done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("mrst_hold_done", 32'(done), 32'd0);
            checkOutput("mrst_hold_sdo", 32'(sdo), 32'd1);
        end
        rst      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        applyStimulus(8'h01, 1'b0, 8'h00, 0, FRAME);
        idleCycle();

        // Randomized frames, mixing held-valid back-to-back and gaps
        armed = 1'b0;
        word  = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            if (!armed) begin
                tx_valid = 1'b1;
                tx_data  = word;
            end
            hold     = (i == 15) ? 1'b0 : 1'($urandom_range(0, 1));
            nextWord = 8'($urandom_range(0, 255));
            corrupt  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0;
            applyStimulus(word, hold, nextWord, corrupt, FRAME);
            idleCycle();
            if (hold) begin
                word  = nextWord;
                armed = 1'b1;
            end else begin
                armed = 1'b0;
                word  = 8'($urandom_range(0, 255));
                repeat ($urandom_range(0, 2)) idleCycle();
            end
        end

        // No-parity, one cycle per bit
        applyStimulus2(8'h80);
        for (int i = 0; i < 4; i++) begin
            applyStimulus2(8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
